// File: rtl/data_memory_responder.sv
// data_memory_responder: word RAM with byte-lane writes, one-cycle read response and LR/SC reservation tracking
package riscv_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] address;
        logic        lr_in_flight;
        logic [31:0] lr_in_flight_addr;
    } reservation_t;
endpackage

module data_memory_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 4096
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req_valid,
    input  logic [XLEN-1:0]         i_data_memory_address,
    input  logic [XLEN-1:0]         i_data_memory_write_data,
    input  logic [3:0]              i_data_memory_byte_write_enable,
    input  logic                    i_is_lr,
    input  logic                    i_is_sc,
    input  logic                    i_reservation_clear,
    output logic                    o_rsp_valid,
    output logic [XLEN-1:0]         o_read_data,
    output logic                    o_access_fault,
    output riscv_pkg::reservation_t o_reservation
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [XLEN-1:0]         mem_q [DEPTH_WORDS];
    logic                    rsp_valid_q;
    logic [XLEN-1:0]         read_data_q;
    logic                    fault_q;
    riscv_pkg::reservation_t res_q, res_d;
    logic                    accept, in_range, is_write, hit_res, hit_lif;
    logic [AW-1:0]           idx;
    logic [XLEN-1:0]         word_addr;

    assign accept    = i_req_valid & ~i_rst;
    assign in_range  = i_data_memory_address[XLEN-1:AW+2] == '0;
    assign is_write  = |i_data_memory_byte_write_enable;
    assign idx       = i_data_memory_address[AW+1:2];
    assign word_addr = {i_data_memory_address[XLEN-1:2], 2'b00};
    assign hit_res   = accept & is_write & ~i_is_sc & (word_addr == res_q.address);
    assign hit_lif   = accept & is_write & ~i_is_sc & (word_addr == res_q.lr_in_flight_addr);

    // Byte-lane RAM write; faulting and reset-cycle requests never touch the array
    always_ff @(posedge i_clk) begin
        if (accept && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (i_data_memory_byte_write_enable[b]) mem_q[idx][8*b +: 8] <= i_data_memory_write_data[8*b +: 8];
            end
        end
    end

    // Registered response: raw word for in-range reads, zero for writes and faults
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_valid_q <= 1'b0;
            read_data_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            rsp_valid_q <= i_req_valid;
            read_data_q <= (i_req_valid && in_range && !is_write) ? mem_q[idx] : '0;
            fault_q     <= i_req_valid & ~in_range;
        end
    end

    // Reservation next state: promote in-flight LR, then apply LR set, SC kill and trap clear in rising priority
    always_comb begin
        res_d       = res_q;
        res_d.valid = res_q.valid & ~hit_res;
        if (res_q.lr_in_flight && !hit_lif) begin
            res_d.valid   = 1'b1;
            res_d.address = res_q.lr_in_flight_addr;
        end
        res_d.lr_in_flight = 1'b0;
        if (accept && i_is_lr && in_range && !i_reservation_clear) begin
            res_d.lr_in_flight      = 1'b1;
            res_d.lr_in_flight_addr = word_addr;
        end
        if (accept && i_is_sc) begin
            res_d.valid        = 1'b0;
            res_d.lr_in_flight = 1'b0;
        end
        if (i_reservation_clear) begin
            res_d.valid        = 1'b0;
            res_d.lr_in_flight = 1'b0;
        end
    end

    // Reservation state register
    always_ff @(posedge i_clk) begin
        if (i_rst) res_q <= '0;
        else res_q <= res_d;
    end

    assign o_rsp_valid    = rsp_valid_q;
    assign o_read_data    = read_data_q;
    assign o_access_fault = fault_q;
    assign o_reservation  = res_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed checks of RAM access, faults, reset and LR/SC reservation
module tb_data_memory_responder;
    logic                    clk = 0;
    logic                    rst = 1;
    logic                    req_valid = 0;
    logic [31:0]             addr = 0;
    logic [31:0]             wdata = 0;
    logic [3:0]              be = 0;
    logic                    is_lr = 0;
    logic                    is_sc = 0;
    logic                    res_clear = 0;
    logic                    rsp_valid;
    logic [31:0]             rdata;
    logic                    fault;
    riscv_pkg::reservation_t res;
    int                      checks = 0;
    int                      failures = 0;

    data_memory_responder #(.XLEN(32), .DEPTH_WORDS(4096)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_req_valid(req_valid),
        .i_data_memory_address(addr),
        .i_data_memory_write_data(wdata),
        .i_data_memory_byte_write_enable(be),
        .i_is_lr(is_lr),
        .i_is_sc(is_sc),
        .i_reservation_clear(res_clear),
        .o_rsp_valid(rsp_valid),
        .o_read_data(rdata),
        .o_access_fault(fault),
        .o_reservation(res)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic lr, input logic sc, input logic clr);
        req_valid = v; addr = a; wdata = d; be = s; is_lr = lr; is_sc = sc; res_clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic rsp(input string tag, input logic v, input logic [31:0] d, input logic f);
        chk({tag, "_valid"}, {31'd0, rsp_valid}, {31'd0, v});
        chk({tag, "_data"}, rdata, d);
        chk({tag, "_fault"}, {31'd0, fault}, {31'd0, f});
    endtask

    task automatic resv(input string tag, input logic v, input logic [31:0] a, input logic l, input logic [31:0] la);
        chk({tag, "_rvalid"}, {31'd0, res.valid}, {31'd0, v});
        chk({tag, "_raddr"}, res.address, a);
        chk({tag, "_lif"}, {31'd0, res.lr_in_flight}, {31'd0, l});
        chk({tag, "_lifaddr"}, res.lr_in_flight_addr, la);
    endtask

    initial begin
        req(0, 0, 0, 4'h0, 0, 0, 0);
        req(0, 0, 0, 4'h0, 0, 0, 0);
        rsp("reset", 0, 0, 0);
        resv("reset", 0, 0, 0, 0);
        rst = 0;
        req(1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        rsp("sw_full", 1, 0, 0);
        req(1, 32'h100, 0, 4'h0, 0, 0, 0);
        rsp("lw_full", 1, 32'hDEADBEEF, 0);
        req(1, 32'h100, 32'h11223344, 4'hF, 0, 0, 0);
        req(1, 32'h101, 32'h0000AA00, 4'h2, 0, 0, 0);
        req(1, 32'h100, 0, 4'h0, 0, 0, 0);
        rsp("lw_byte", 1, 32'h1122AA44, 0);
        req(1, 32'h102, 32'hBEEF0000, 4'hC, 0, 0, 0);
        req(1, 32'h100, 0, 4'h0, 0, 0, 0);
        rsp("lw_half", 1, 32'hBEEFAA44, 0);
        req(1, 32'h104, 32'h55555555, 4'hF, 0, 0, 0);
        req(1, 32'h104, 0, 4'h0, 0, 0, 0);
        rsp("b2b_rd1", 1, 32'h55555555, 0);
        req(1, 32'h104, 32'h01020304, 4'hF, 0, 0, 0);
        rsp("b2b_wr", 1, 0, 0);
        req(1, 32'h104, 0, 4'h0, 0, 0, 0);
        rsp("b2b_rd2", 1, 32'h01020304, 0);
        req(1, 32'h104, 32'hAABBCCDD, 4'h5, 0, 0, 0);
        req(1, 32'h104, 0, 4'h0, 0, 0, 0);
        rsp("odd_strobe", 1, 32'h01BB03DD, 0);
        req(0, 0, 0, 4'h0, 0, 0, 0);
        rsp("idle", 0, 0, 0);
        req(1, 32'h200, 0, 4'h0, 1, 0, 0);
        resv("lr_t1", 0, 0, 1, 32'h200);
        req(0, 0, 0, 4'h0, 0, 0, 0);
        resv("lr_t2", 1, 32'h200, 0, 32'h200);
        req(1, 32'h202, 32'h00770000, 4'h4, 0, 0, 0);
        resv("sw_kill", 0, 32'h200, 0, 32'h200);
        req(1, 32'h200, 32'h12345678, 4'hF, 0, 1, 0);
        resv("sc_after", 0, 32'h200, 0, 32'h200);
        req(1, 32'h302, 0, 4'h0, 1, 0, 0);
        req(0, 0, 0, 4'h0, 0, 0, 0);
        resv("lr2", 1, 32'h300, 0, 32'h300);
        req(1, 32'h300, 0, 4'h0, 0, 1, 0);
        resv("sc_kill", 0, 32'h300, 0, 32'h300);
        req(1, 32'h204, 0, 4'h0, 1, 0, 1);
        resv("lr_clr", 0, 32'h300, 0, 32'h300);
        req(1, 32'h208, 0, 4'h0, 1, 0, 0);
        resv("lr3", 0, 32'h300, 1, 32'h208);
        rst = 1;
        req(1, 32'h100, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        rsp("mid_rst", 0, 0, 0);
        resv("mid_rst", 0, 0, 0, 0);
        rst = 0;
        req(0, 0, 0, 4'h0, 0, 0, 0);
        rsp("rst_drop", 0, 0, 0);
        req(1, 32'h100, 0, 4'h0, 0, 0, 0);
        rsp("rst_nowrite", 1, 32'hBEEFAA44, 0);
        req(1, 32'h0, 32'hCAFEF00D, 4'hF, 0, 0, 0);
        req(1, 32'h4000, 32'h12345678, 4'hF, 0, 0, 0);
        rsp("fault_wr", 1, 0, 1);
        req(1, 32'h0, 0, 4'h0, 0, 0, 0);
        rsp("fault_nowr", 1, 32'hCAFEF00D, 0);
        req(1, 32'h4000, 0, 4'h0, 1, 0, 0);
        rsp("fault_lr", 1, 0, 1);
        resv("fault_lr", 0, 0, 0, 0);
        req(1, 32'h3FFC, 32'h0BADF00D, 4'hF, 0, 0, 0);
        req(1, 32'h3FFC, 0, 4'h0, 0, 0, 0);
        rsp("last_word", 1, 32'h0BADF00D, 0);
        req(0, 0, 0, 4'h0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
